// File: rtl/apb_gpio_irq.sv
// APB slave GPIO controller: direction/output registers with atomic set/clear
// aliases, a two-flop synchronised input path and per-pin edge interrupts
// with enable, polarity and write-1-to-clear status.
module apb_gpio_irq #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4,
  parameter int WARMUP = 3
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [WIDTH-1:0]  PWDATA,
  output logic [WIDTH-1:0]  PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  localparam int CNT_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

  logic [WIDTH-1:0] dir_q, out_q, en_q, pol_q, stat_q;
  logic [WIDTH-1:0] sync_p0, sync_p1, prev_p2;
  logic [WIDTH-1:0] evt, w1c;
  logic [CNT_W-1:0] warm_cnt;
  logic             warm_done;
  logic             irq_q;
  logic             addr_err;
  logic             access;
  logic             wr;
  logic [2:0]       idx;

  // Any address bit above the 8-word map flags an error; these words must
  // never alias onto the real registers.
  generate
    if (ADDR_W > 3) begin : g_hi
      assign addr_err = |PADDR[ADDR_W-1:3];
    end else begin : g_nohi
      assign addr_err = 1'b0;
    end
  endgenerate

  assign idx     = PADDR[2:0];
  assign access  = PSEL & PENABLE;
  assign wr      = access & PWRITE & ~addr_err;
  assign PREADY  = 1'b1;
  assign PSLVERR = access & addr_err;

  assign w1c       = (wr && idx == 3'd7) ? PWDATA : '0;
  assign warm_done = (warm_cnt == CNT_W'(WARMUP));
  // Only pins configured as inputs can raise events; the polarity bit picks
  // which transition of the synchronised level counts.
  assign evt = ~dir_q & {WIDTH{warm_done}} &
               ((pol_q & prev_p2 & ~sync_p1) | (~pol_q & ~prev_p2 & sync_p1));

  // Configuration and output registers written from the APB access phase.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      dir_q <= '0;
      out_q <= '0;
      en_q  <= '0;
      pol_q <= '0;
    end else if (wr) begin
      case (idx)
        3'd0: dir_q <= PWDATA;
        3'd1: out_q <= out_q | PWDATA;
        3'd2: out_q <= out_q & ~PWDATA;
        3'd3: out_q <= PWDATA;
        3'd5: en_q  <= PWDATA;
        3'd6: pol_q <= PWDATA;
        default: ;
      endcase
    end
  end

  // Input pipeline: p0/p1 resynchronise the pads, p2 holds the previous
  // synchronised level for edge comparison.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= '0;
    end else begin
      // stage p0: first metastability flop
      sync_p0 <= gpio_in;
      // stage p1: stable synchronised level
      sync_p1 <= sync_p0;
      // stage p2: edge history
      prev_p2 <= sync_p1;
    end
  end

  // Warm-up counter masks the spurious edge from pads already high at reset.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      warm_cnt <= '0;
    end else if (warm_cnt < CNT_W'(WARMUP)) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  // Sticky status: a new event beats a simultaneous write-1-to-clear.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      stat_q <= '0;
    end else begin
      stat_q <= (stat_q & ~w1c) | evt;
    end
  end

  // Registered interrupt level from enabled status bits.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(stat_q & en_q);
    end
  end

  // Read mux; out-of-map words and write cycles return zero.
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE && !addr_err) begin
      case (idx)
        3'd0:          PRDATA = dir_q;
        3'd1, 3'd2, 3'd3: PRDATA = out_q;
        3'd4:          PRDATA = sync_p1;
        3'd5:          PRDATA = en_q;
        3'd6:          PRDATA = pol_q;
        3'd7:          PRDATA = stat_q;
        default:       PRDATA = '0;
      endcase
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Bench for apb_gpio_irq: directed APB/pad stimulus, expected responses
// queued in a scoreboard and checked by an independent monitor.
module tb_apb_gpio_irq;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [W-1:0]  PWDATA, PRDATA;
  logic          PREADY, PSLVERR;
  logic [W-1:0]  gpio_in, gpio_out, gpio_oe;
  logic          irq;
  logic          probe;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         is_apb;
    string      name;
    logic [7:0] rdata;
    logic       err;
    logic [7:0] oe;
    logic [7:0] out;
    logic       irq;
  } exp_t;

  exp_t sbq[$];

  apb_gpio_irq #(.WIDTH(W), .ADDR_W(AW), .WARMUP(3)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_apb(input string n, input logic [7:0] d, input logic e);
    exp_t x;
    x.is_apb = 1'b1; x.name = n; x.rdata = d; x.err = e;
    x.oe = '0; x.out = '0; x.irq = 1'b0;
    sbq.push_back(x);
  endfunction

  function automatic void push_pins(input string n, input logic [7:0] oe,
                                    input logic [7:0] out, input logic iq);
    exp_t x;
    x.is_apb = 1'b0; x.name = n; x.rdata = '0; x.err = 1'b0;
    x.oe = oe; x.out = out; x.irq = iq;
    sbq.push_back(x);
  endfunction

  // Monitor: compares on every ACCESS phase and on every pin probe.
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow_apb actual=empty expected=entry");
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_kind"}, 32'(e.is_apb), 32'd1);
          chk({e.name, "_prdata"}, 32'(PRDATA), 32'(e.rdata));
          chk({e.name, "_pslverr"}, 32'(PSLVERR), 32'(e.err));
          chk({e.name, "_pready"}, 32'(PREADY), 32'd1);
        end
      end
      if (probe) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow_pins actual=empty expected=entry");
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_kind"}, 32'(e.is_apb), 32'd0);
          chk({e.name, "_oe"}, 32'(gpio_oe), 32'(e.oe));
          chk({e.name, "_out"}, 32'(gpio_out), 32'(e.out));
          chk({e.name, "_irq"}, 32'(irq), 32'(e.irq));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge PCLK); #1;
    end
  endtask

  task automatic apb_wr(input string n, input logic [AW-1:0] a, input logic [7:0] d,
                        input logic e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    push_apb(n, 8'h00, e);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_rd(input string n, input logic [AW-1:0] a, input logic [7:0] d,
                        input logic e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    push_apb(n, d, e);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic pins(input string n, input logic [7:0] oe, input logic [7:0] out,
                      input logic iq);
    push_pins(n, oe, out, iq);
    probe = 1'b1;
    @(posedge PCLK); #1;
    probe = 1'b0;
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    idle(2);
    PRESETn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; gpio_in = '0; probe = 1'b0;
    idle(3);
    PRESETn = 1'b1;

    // 1: reset state
    pins("rst_pins", 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) apb_rd($sformatf("rst_rd%0d", i), AW'(i), 8'h00, 1'b0);

    // 2: DIR/OUT/SET/CLR
    apb_wr("wr_dir", 4'd0, 8'h0F, 1'b0);
    apb_wr("wr_out", 4'd3, 8'h05, 1'b0);
    apb_wr("wr_set", 4'd1, 8'h08, 1'b0);
    apb_wr("wr_clr", 4'd2, 8'h01, 1'b0);
    pins("out_pins", 8'h0F, 8'h0C, 1'b0);
    apb_rd("rd_out", 4'd3, 8'h0C, 1'b0);
    apb_rd("rd_set_alias", 4'd1, 8'h0C, 1'b0);
    apb_rd("rd_dir", 4'd0, 8'h0F, 1'b0);

    // 3: inputs high through reset, warm-up suppresses the false edge
    gpio_in = 8'hFF;
    do_reset();
    apb_wr("warm_en", 4'd5, 8'hFF, 1'b0);
    idle(3);
    apb_rd("warm_stat", 4'd7, 8'h00, 1'b0);
    apb_rd("warm_in", 4'd4, 8'hFF, 1'b0);
    pins("warm_pins", 8'h00, 8'h00, 1'b0);

    // 4: rising edge on pin 0, W1C, falling edge ignored with POL=0
    apb_wr("e4_en", 4'd5, 8'h01, 1'b0);
    gpio_in = 8'h00;
    idle(5);
    apb_rd("fall_all_stat", 4'd7, 8'h00, 1'b0);
    gpio_in = 8'h01;
    idle(1);
    apb_rd("rise_stat_e2", 4'd7, 8'h00, 1'b0);
    pins("rise_irq_e3", 8'h00, 8'h00, 1'b0);
    pins("rise_irq_e4", 8'h00, 8'h00, 1'b1);
    apb_rd("rise_stat", 4'd7, 8'h01, 1'b0);
    apb_rd("rise_in", 4'd4, 8'h01, 1'b0);
    apb_wr("w1c_0", 4'd7, 8'h01, 1'b0);
    pins("w1c_irq_same", 8'h00, 8'h00, 1'b1);
    pins("w1c_irq_next", 8'h00, 8'h00, 1'b0);
    apb_rd("w1c_stat", 4'd7, 8'h00, 1'b0);
    gpio_in = 8'h00;
    idle(5);
    apb_rd("fall0_stat", 4'd7, 8'h00, 1'b0);
    pins("fall0_irq", 8'h00, 8'h00, 1'b0);

    // 5: falling polarity, event coincident with W1C, output pin ignored
    apb_wr("e5_pol", 4'd6, 8'h02, 1'b0);
    apb_wr("e5_en", 4'd5, 8'h02, 1'b0);
    gpio_in = 8'h02;
    idle(5);
    apb_rd("pol_rise_stat", 4'd7, 8'h00, 1'b0);
    gpio_in = 8'h00;
    idle(1);
    apb_wr("collide_w1c", 4'd7, 8'h02, 1'b0);
    apb_rd("collide_stat", 4'd7, 8'h02, 1'b0);
    pins("collide_irq", 8'h00, 8'h00, 1'b1);
    apb_wr("clr1", 4'd7, 8'h02, 1'b0);
    apb_rd("clr1_stat", 4'd7, 8'h00, 1'b0);
    apb_wr("dir1", 4'd0, 8'h02, 1'b0);
    gpio_in = 8'h02;
    idle(4);
    gpio_in = 8'h00;
    idle(5);
    apb_rd("outpin_stat", 4'd7, 8'h00, 1'b0);
    pins("outpin_pins", 8'h02, 8'h00, 1'b0);

    // 6: out-of-map access, then reset during ACCESS
    apb_wr("e6_out", 4'd3, 8'h5A, 1'b0);
    apb_wr("err_wr", 4'd9, 8'hAA, 1'b1);
    apb_rd("err_rd", 4'd9, 8'h00, 1'b1);
    apb_rd("err_out", 4'd3, 8'h5A, 1'b0);
    apb_rd("err_dir", 4'd0, 8'h02, 1'b0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'd3;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    push_apb("rstmid_rd", 8'h00, 1'b0);
    #1;
    PRESETn = 1'b0;
    push_pins("rstmid_pins", 8'h00, 8'h00, 1'b0);
    probe = 1'b1;
    @(posedge PCLK); #1;
    probe = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    idle(1);
    PRESETn = 1'b1;
    apb_rd("post_rst_dir", 4'd0, 8'h00, 1'b0);
    apb_rd("post_rst_pol", 4'd6, 8'h00, 1'b0);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge PCLK);
    if (sbq.size() != 0) begin
      checks++; failures++;
      $display("FAIL sb_drain actual=%0d expected=0", sbq.size());
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
